// File: rtl/cdc_pulse_tx.sv
// Source side of a two-phase toggle pulse crossing: launches one req_tgl flip per
// din rising edge, queues events while a handshake is outstanding, and watches ack.
module cdc_pulse_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk_src,
    input  logic              rst_n,
    input  logic              din,
    input  logic              ack_async,
    output logic              req_tgl,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              sent,
    output logic              drop,
    output logic              err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic                   r_din_q;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_tgl;
    logic [PEND_W-1:0]      r_pending;
    logic                   r_sent;
    logic                   r_drop;
    logic                   r_err;

    logic   w_ev;
    logic   w_ack_s;
    logic   w_ack_chg;
    logic   w_full;
    state_t w_state;

    // Event detect, synchronized ack and the handshake state derived from registers.
    always_comb begin
        w_ev      = din & ~r_din_q;
        w_ack_s   = r_sync[SYNC_STAGES-1];
        w_ack_chg = r_sync[SYNC_STAGES-2] ^ r_sync[SYNC_STAGES-1];
        w_full    = &r_pending;
        if (r_req_tgl == w_ack_s) begin
            w_state = ST_IDLE;
        end else begin
            w_state = ST_WAIT;
        end
    end

    // Edge-detect flop, ack synchronizer and the one-cycle status pulses.
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            r_din_q <= 1'b0;
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_sent  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_din_q <= din;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ack_async};
            r_sent  <= w_ack_chg;
            // An ack toggle with nothing outstanding means the two sides disagree.
            if (w_ack_chg && (w_state == ST_IDLE)) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Launch/queue engine: drain the queue first, fast-path when empty, saturate on overflow.
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            r_req_tgl <= 1'b0;
            r_pending <= PEND_ZERO;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (w_state)
                ST_IDLE: begin
                    if (r_pending != PEND_ZERO) begin
                        r_req_tgl <= ~r_req_tgl;
                        if (!w_ev) begin
                            r_pending <= r_pending - PEND_ONE;
                        end else begin
                            r_pending <= r_pending;
                        end
                    end else if (w_ev) begin
                        r_req_tgl <= ~r_req_tgl;
                    end else begin
                        r_req_tgl <= r_req_tgl;
                    end
                end
                ST_WAIT: begin
                    if (w_ev) begin
                        if (!w_full) begin
                            r_pending <= r_pending + PEND_ONE;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end else begin
                        r_pending <= r_pending;
                    end
                end
                default: begin
                    r_req_tgl <= r_req_tgl;
                    r_pending <= r_pending;
                end
            endcase
        end
    end

    assign req_tgl = r_req_tgl;
    assign pending = r_pending;
    assign sent    = r_sent;
    assign drop    = r_drop;
    assign err     = r_err;
    assign busy    = (r_req_tgl != w_ack_s) | (r_pending != PEND_ZERO);

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Directed bench for cdc_pulse_tx (SYNC_STAGES=2, PEND_W=2); the bench drives ack_async
// by hand as the destination loopback and checks outputs 1 ns after each rising edge.
module tb_cdc_pulse_tx;

    logic       clk_src;
    logic       rst_n;
    logic       din;
    logic       ack_async;
    logic       req_tgl;
    logic       busy;
    logic [1:0] pending;
    logic       sent;
    logic       drop;
    logic       err;

    int total;
    int bad;
    int sent_cnt;
    logic exp_req;

    // Observation vector: {req_tgl, busy, pending[1:0], sent, drop, err}
    logic [6:0] obs;
    assign obs = {req_tgl, busy, pending, sent, drop, err};

    cdc_pulse_tx #(.SYNC_STAGES(2), .PEND_W(2)) dut (
        .clk_src  (clk_src),
        .rst_n    (rst_n),
        .din      (din),
        .ack_async(ack_async),
        .req_tgl  (req_tgl),
        .busy     (busy),
        .pending  (pending),
        .sent     (sent),
        .drop     (drop),
        .err      (err)
    );

    initial clk_src = 1'b0;
    always #5 clk_src = ~clk_src;

    always @(negedge clk_src) begin
        if (sent === 1'b1) sent_cnt++;
    end

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b0; ack_async = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = ~din; ack_async = ~ack_async;
            tick();
            total++;
            if (obs !== 7'b0000000) begin
                bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0000000);
            end
        end
        din = 1'b0; ack_async = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== 7'b0000000) begin
                bad++; $display("FAIL reset_release got=%b exp=%b", obs, 7'b0000000);
            end
        end
        exp_req = 1'b0;
    endtask

    task automatic test_single_event();
        sent_cnt = 0;
        din = 1'b1;
        tick();
        din = 1'b0;
        exp_req = ~exp_req;
        total++;
        if (obs !== {exp_req, 6'b100000}) begin
            bad++; $display("FAIL single_launch got=%b exp=%b", obs, {exp_req, 6'b100000});
        end
        ack_async = exp_req;
        tick();
        total++;
        if (obs !== {exp_req, 6'b100000}) begin
            bad++; $display("FAIL single_sync1 got=%b exp=%b", obs, {exp_req, 6'b100000});
        end
        tick();
        total++;
        if (obs !== {exp_req, 6'b000100}) begin
            bad++; $display("FAIL single_sent got=%b exp=%b", obs, {exp_req, 6'b000100});
        end
        tick();
        total++;
        if (obs !== {exp_req, 6'b000000} || sent_cnt != 1) begin
            bad++; $display("FAIL single_done got=%b exp=%b sent_cnt=%0d exp=1", obs, {exp_req, 6'b000000}, sent_cnt);
        end
    endtask

    task automatic test_multi_cycle_din();
        sent_cnt = 0;
        din = 1'b1;
        tick();
        exp_req = ~exp_req;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== {exp_req, 6'b100000}) begin
                bad++; $display("FAIL multi_hold got=%b exp=%b", obs, {exp_req, 6'b100000});
            end
        end
        din = 1'b0;
        ack_async = exp_req;
        tick(); tick();
        total++;
        if (obs !== {exp_req, 6'b000100}) begin
            bad++; $display("FAIL multi_sent got=%b exp=%b", obs, {exp_req, 6'b000100});
        end
        tick(); tick();
        total++;
        if (sent_cnt != 1 || obs !== {exp_req, 6'b000000}) begin
            bad++; $display("FAIL multi_count got=%0d exp=1 obs=%b", sent_cnt, obs);
        end
    endtask

    task automatic test_back_to_back();
        sent_cnt = 0;
        din = 1'b1; tick(); din = 1'b0;
        exp_req = ~exp_req;
        tick();
        din = 1'b1; tick(); din = 1'b0;
        total++;
        if (obs !== {exp_req, 6'b101000}) begin
            bad++; $display("FAIL b2b_queue got=%b exp=%b", obs, {exp_req, 6'b101000});
        end
        tick(); tick(); tick();
        ack_async = exp_req;
        tick(); tick();
        total++;
        if (obs !== {exp_req, 6'b101100}) begin
            bad++; $display("FAIL b2b_first_sent got=%b exp=%b", obs, {exp_req, 6'b101100});
        end
        tick();
        exp_req = ~exp_req;
        total++;
        if (obs !== {exp_req, 6'b100000}) begin
            bad++; $display("FAIL b2b_second_launch got=%b exp=%b", obs, {exp_req, 6'b100000});
        end
        ack_async = exp_req;
        tick(); tick(); tick();
        total++;
        if (sent_cnt != 2 || obs !== {exp_req, 6'b000000}) begin
            bad++; $display("FAIL b2b_end sent_cnt=%0d exp=2 obs=%b exp=%b", sent_cnt, obs, {exp_req, 6'b000000});
        end
    endtask

    task automatic test_overflow();
        sent_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            din = 1'b1; tick(); din = 1'b0; tick();
        end
        exp_req = ~exp_req;
        total++;
        if (obs !== {exp_req, 6'b111000}) begin
            bad++; $display("FAIL ovf_full got=%b exp=%b", obs, {exp_req, 6'b111000});
        end
        din = 1'b1; tick(); din = 1'b0;
        total++;
        if (obs !== {exp_req, 6'b111010}) begin
            bad++; $display("FAIL ovf_drop got=%b exp=%b", obs, {exp_req, 6'b111010});
        end
        tick();
        total++;
        if (obs !== {exp_req, 6'b111000}) begin
            bad++; $display("FAIL ovf_drop_width got=%b exp=%b", obs, {exp_req, 6'b111000});
        end
        for (int i = 3; i > 0; i--) begin
            ack_async = exp_req;
            tick(); tick(); tick();
            exp_req = ~exp_req;
            total++;
            if (obs !== {exp_req, 1'b1, 2'(i - 1), 3'b000}) begin
                bad++; $display("FAIL ovf_drain got=%b exp=%b", obs, {exp_req, 1'b1, 2'(i - 1), 3'b000});
            end
        end
        ack_async = exp_req;
        tick(); tick(); tick();
        total++;
        if (sent_cnt != 4 || obs !== {exp_req, 6'b000000}) begin
            bad++; $display("FAIL ovf_end sent_cnt=%0d exp=4 obs=%b exp=%b", sent_cnt, obs, {exp_req, 6'b000000});
        end
    endtask

    task automatic test_error_and_reset();
        ack_async = ~exp_req;
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_early got=%b exp=0", err);
        end
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_set got=%b exp=1", err);
        end
        for (int i = 0; i < 2; i++) begin
            din = 1'b1; tick(); din = 1'b0; tick();
        end
        total++;
        if (obs !== {exp_req, 6'b110001}) begin
            bad++; $display("FAIL err_sticky got=%b exp=%b", obs, {exp_req, 6'b110001});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 7'b0000000) begin
            bad++; $display("FAIL async_reset got=%b exp=%b", obs, 7'b0000000);
        end
        ack_async = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0; bad = 0; sent_cnt = 0; exp_req = 1'b0;
        rst_n = 1'b0; din = 1'b0; ack_async = 1'b0;
        test_reset();
        test_single_event();
        test_multi_cycle_din();
        test_back_to_back();
        test_overflow();
        test_error_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_pulse_tx.md
# cdc_pulse_tx

Source-side transmitter for a two-phase toggle pulse-crossing handshake, clocked entirely in `clk_src`. Each rising edge of `din` is one event. The block launches each event to the destination domain by flipping `req_tgl`. It waits for the destination's returned toggle `ack_async` before it launches the next event. Events that arrive while a handshake is outstanding are queued in a saturating pending counter, so back-to-back source pulses are not lost up to the configured depth.

## Interface
- `SYNC_STAGES`, default 2: flops in the `ack_async` synchronizer; legal range ≥ 2.
- `PEND_W`, default 3: width of the pending counter; the queue holds at most 2^PEND_W − 1 events.
- `clk_src` in 1: source clock; the only clock in the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 1: event request; every 0→1 transition seen on `clk_src` is one event.
- `ack_async` in 1: acknowledge toggle returned from the destination domain; asynchronous to `clk_src`.
- `req_tgl` out 1: registered request toggle sent to the destination.
- `busy` out 1: a handshake is outstanding or the queue is non-empty.
- `pending` out PEND_W: number of queued events not yet launched.
- `sent` out 1: one-cycle pulse, one per completed handshake.
- `drop` out 1: one-cycle pulse; an event was discarded because the queue was full.
- `err` out 1: sticky flag; an acknowledge toggle arrived with no handshake outstanding.

## Operation
- **Reset values:** all flops clear to 0, so `req_tgl`, `sent`, `drop`, `err` = 0, `pending` = 0 and `busy` = 0. The input edge-detect flop `din_q` and every synchronizer stage also clear to 0.
- **Event detection:** `ev = din & ~din_q`, with `din_q <= din` every cycle. A `din` level held high for several cycles produces one event.
- **Acknowledge synchronizer:** `ack_async` passes through a chain `s[0..SYNC_STAGES-1]`. The synchronized value is `ack_s = s[SYNC_STAGES-1]`.
- **States**, derived from registers with no extra state flop:
  - IDLE when `req_tgl == ack_s`.
  - WAIT otherwise.
- **Per-edge update, in priority order:**
  - IDLE and `pending > 0`: toggle `req_tgl`. If `ev` is also high, `pending` is unchanged (one in, one out); otherwise `pending − 1`.
  - IDLE, `pending == 0`, `ev`: toggle `req_tgl`. `pending` stays 0 (fast path, no queueing).
  - WAIT and `ev`:
    - if `pending < 2^PEND_W − 1`, `pending + 1`;
    - else `pending` is unchanged and `drop <= 1` for one cycle.
  - Otherwise: hold.
- **`sent`:** `sent <= s[SYNC_STAGES-2] ^ s[SYNC_STAGES-1]`. It rises on the same edge at which `ack_s` changes.
- **`err`:** set and held when `ack_s` changes while the block was IDLE before that edge. Only reset clears it.
- **`busy`:** combinational, `(req_tgl != ack_s) | (pending != 0)`.
- **Arithmetic:** `pending` is unsigned PEND_W bits. It never wraps: increments saturate with `drop`, and a decrement never occurs at 0.
- **Reset mid-handshake:** all state returns to reset values immediately and any queued events are discarded. The destination must be reset concurrently; this block has no recovery beyond reset.

## Timing
- **Launch latency:**
  - `din` is sampled high at edge N with `din_q` = 0 and the block is IDLE with an empty queue.
  - `req_tgl` flips at edge N and is visible in the cycle after N.
- **Acknowledge latency:**
  - `ack_async` changes between edges K−1 and K.
  - `s[0]` captures it at edge K, and `ack_s` and `sent` update at edge K+SYNC_STAGES−1.
- **Next launch:** a queued event launches at the edge after `ack_s` updates, i.e. K+SYNC_STAGES.
- **Throughput:** the minimum spacing between launches is the destination round trip plus SYNC_STAGES+1 cycles.
- **Output pulses:** `sent` and `drop` are exactly one cycle wide each time they fire.

## Test plan
- **Reset:** hold `rst_n` = 0 while toggling `din` and `ack_async` → all outputs stay 0. Release `rst_n` → outputs remain 0 until the first `din` rise.
- **Single event:**
  - Raise `din` for one cycle, sampled at edge 10 → `req_tgl` = 1 after edge 10 and `busy` = 1.
  - Bench raises `ack_async` before edge 15 → `ack_s` and `sent` go high after edge 16 (SYNC_STAGES = 2), and `busy` = 0 after edge 16.
- **Multi-cycle `din`:** hold `din` high for 4 cycles → exactly one `req_tgl` flip, `pending` stays 0, and one `sent` follows the acknowledge.
- **Back-to-back events:**
  - Two `din` rises 2 cycles apart, with the acknowledge loopback delayed 6 cycles → `pending` = 1 during WAIT.
  - The second flip occurs at the edge after `ack_s` updates, then `pending` = 0.
  - The loopback returns both acknowledges → two `sent` pulses in total and `busy` = 0 at the end.
- **Overflow:** PEND_W = 2, acknowledge withheld, 5 `din` rises → the 1st launches and the 2nd–4th queue (`pending` = 3). The 5th gives one `drop` pulse with `pending` still 3. Releasing acknowledges drains 3 further launches, for 4 `sent` in total.
- **Protocol error and mid-operation reset:**
  - Toggle `ack_async` while IDLE → `err` = 1 two edges later and it stays high.
  - Assert `rst_n` with `pending` = 2 → `err`, `pending` and `req_tgl` clear asynchronously.
